// File: rtl/dmem_line_responder_pkg.sv
// rtl/dmem_line_responder_pkg.sv - shared types and constants for the dcache line responder
//
// Purpose : FSM state encoding, line geometry constants and a small helper
//           used to size the latency counter.
// Ports   : none (package)
package dmem_line_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    TURN = 2'd3
  } type_dmem_state_e;

  localparam int DMEM_LINE_BYTES  = 16;
  localparam int DMEM_OFFSET_BITS = 4;

  function automatic int dmem_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dmem_line_ram.sv
// rtl/dmem_line_ram.sv - line-wide single-port storage with registered read
//
// Purpose : DEPTH_LINES x LINE_WIDTH array. Contents are not reset.
// Ports   : clk    in  clock
//           wr_en  in  write strobe, commits wdata to addr
//           rd_en  in  read strobe, rdata updates on the next edge
//           addr   in  line index
//           wdata  in  line to write
//           rdata  out registered line read (holds when rd_en=0)
module dmem_line_ram #(
  parameter int DEPTH_LINES = 1024,
  parameter int LINE_WIDTH  = 128
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_LINES)-1:0] addr,
  input  logic [LINE_WIDTH-1:0]          wdata,
  output logic [LINE_WIDTH-1:0]          rdata
);

  logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - memory-side line responder for the write-back dcache
//
// Purpose : Services one refill read or dirty-line writeback at a time with a
//           programmable latency and a req/ack handshake.
// Ports   : clk, rst_n              clock, synchronous active-low reset
//           dcache2mem_req_i        request valid (sampled only in IDLE)
//           dcache2mem_wr_i         1 = writeback, 0 = refill read
//           dcache2mem_addr_i       byte address, low 4 bits ignored
//           dcache2mem_data_i       writeback line
//           mem2dcache_data_o       refill line, valid with ack on reads
//           mem2dcache_ack_o        one-cycle completion pulse
//           mem2dcache_err_o        address out of range, valid with ack
//           mem_busy_o              transaction in flight
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    LINE_WIDTH  = 128,
  parameter int                    DEPTH_LINES = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    RD_LATENCY  = 4,
  parameter int                    WR_LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
  output logic                  mem2dcache_ack_o,
  output logic                  mem2dcache_err_o,
  output logic                  mem_busy_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(dmem_max(RD_LATENCY, WR_LATENCY) + 1);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH_LINES * DMEM_LINE_BYTES);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  type_dmem_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] data_q;

  logic                  accept;
  logic                  last_busy;
  logic [ADDR_WIDTH-1:0] off;
  logic                  in_range;
  logic [IDX_W-1:0]      line_idx;
  logic [LINE_WIDTH-1:0] ram_rdata;
  logic [LINE_WIDTH-1:0] resp_data;

  // Offset is computed modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR
  // wrap to large values and fail the range check as well.
  assign off       = addr_q - BASE_ADDR;
  assign in_range  = (off < SPAN);
  assign line_idx  = off[DMEM_OFFSET_BITS +: IDX_W];
  assign last_busy = (state_q == BUSY) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dcache2mem_req_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        cnt_q <= dcache2mem_wr_i ? WR_LOAD : RD_LOAD;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == RESP) begin
        data_q <= resp_data;
      end
    end
  end

  // Request latches are only loaded on accept; anything on the inputs while
  // the transaction is in flight is ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= dcache2mem_addr_i;
      wr_q    <= dcache2mem_wr_i;
      wdata_q <= dcache2mem_data_i;
    end
  end

  // Both the commit and the read happen on the last BUSY cycle, so the
  // registered read data lines up with RESP.
  dmem_line_ram #(
    .DEPTH_LINES (DEPTH_LINES),
    .LINE_WIDTH  (LINE_WIDTH)
  ) u_ram (
    .clk   (clk),
    .wr_en (last_busy && wr_q && in_range),
    .rd_en (last_busy && !wr_q),
    .addr  (line_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign resp_data = (!wr_q && in_range) ? ram_rdata : '0;

  assign mem2dcache_ack_o  = (state_q == RESP);
  assign mem2dcache_err_o  = (state_q == RESP) && !in_range;
  assign mem2dcache_data_o = (state_q == RESP) ? resp_data : data_q;
  assign mem_busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - self-checking bench for dmem_line_responder
//
// Purpose : Two instances (latency 4 / depth 1024 and latency 1 / depth 16)
//           driven from a single clock; responses checked against a scoreboard.
// Ports   : none
module tb_dmem_line_responder;

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         req   [2];
  logic         wr    [2];
  logic [31:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];
  logic         ack   [2];
  logic         err   [2];
  logic         busy  [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 0;
  int   prev_acc [2];
  exp_t sb0 [$];
  exp_t sb1 [$];

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D2 = 128'hFEED_FACE_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D4 = 128'h0BAD_CAFE_0BAD_CAFE_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D5 = 128'hC001_D00D_C001_D00D_C001_D00D_C001_D00D;
  localparam logic [127:0] P5 = {8{16'h5555}};
  localparam logic [127:0] PA = {8{16'hAAAA}};

  dmem_line_responder #(
    .ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(1024),
    .BASE_ADDR(32'h8000_0000), .RD_LATENCY(4), .WR_LATENCY(4)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .dcache2mem_req_i(req[0]), .dcache2mem_wr_i(wr[0]),
    .dcache2mem_addr_i(addr[0]), .dcache2mem_data_i(wdata[0]),
    .mem2dcache_data_o(rdata[0]), .mem2dcache_ack_o(ack[0]),
    .mem2dcache_err_o(err[0]), .mem_busy_o(busy[0])
  );

  dmem_line_responder #(
    .ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(16),
    .BASE_ADDR(32'h0000_1000), .RD_LATENCY(1), .WR_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .dcache2mem_req_i(req[1]), .dcache2mem_wr_i(wr[1]),
    .dcache2mem_addr_i(addr[1]), .dcache2mem_data_i(wdata[1]),
    .mem2dcache_data_o(rdata[1]), .mem2dcache_ack_o(ack[1]),
    .mem2dcache_err_o(err[1]), .mem_busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input int d, input exp_t e);
    check($sformatf("resp_data%0d", d), rdata[d], e.data);
    check($sformatf("resp_err%0d", d), 128'(err[d]), 128'(e.err));
    check($sformatf("resp_lat%0d", d), 128'(cyc - e.acc + 1), 128'(e.lat));
  endtask

  // Scoreboard side: every ack must match the oldest pushed expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (armed) begin
      if (ack[0]) begin
        if (sb0.size() == 0) check("spurious_ack0", 128'(1), 128'(0));
        else begin
          e = sb0.pop_front();
          check_resp(0, e);
        end
      end
      if (ack[1]) begin
        if (sb1.size() == 0) check("spurious_ack1", 128'(1), 128'(0));
        else begin
          e = sb1.pop_front();
          check_resp(1, e);
        end
      end
    end
  end

  // One transaction. hold keeps req high through RESP and TURN (caller must
  // follow with another txn or idle()); wig scrambles inputs while busy and
  // drops req early; gap>0 checks spacing from the previous accept.
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [127:0] wd, input logic [127:0] ed,
                     input logic ee, input int lat, input bit hold,
                     input bit wig, input int gap);
    int   n;
    exp_t e;
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    while (busy[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy[d]) check($sformatf("accept_timeout%0d", d), 128'(1), 128'(0));
    @(posedge clk);
    #1;
    e.data = ed; e.err = ee; e.lat = lat; e.acc = cyc;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    if (gap > 0) check($sformatf("accept_gap%0d", d), 128'(cyc - prev_acc[d]), 128'(gap));
    prev_acc[d] = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ack[d] && wig) begin
        addr[d]  = $urandom;
        wdata[d] = {$urandom, $urandom, $urandom, $urandom};
        wr[d]    = ~w;
        req[d]   = 1'b0;
      end
    end while (!ack[d] && n < 40);
    if (!ack[d]) check($sformatf("ack_timeout%0d", d), 128'(0), 128'(1));
    if (!hold) req[d] = 1'b0;
    else begin
      @(negedge clk);
      check($sformatf("turn_ack%0d", d), 128'(ack[d]), 128'(0));
      check($sformatf("turn_busy%0d", d), 128'(busy[d]), 128'(1));
      check($sformatf("turn_hold%0d", d), rdata[d], ed);
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    req[d] = 1'b0;
    check($sformatf("idle_busy%0d", d), 128'(busy[d]), 128'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b1; wr[d] = 1'b1; addr[d] = 32'h8000_0040; wdata[d] = D1;
      prev_acc[d] = 0;
    end

    // Reset with req asserted: nothing may start.
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rst_ack%0d", d), 128'(ack[d]), 128'(0));
        check($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'(0));
        check($sformatf("rst_err%0d", d), 128'(err[d]), 128'(0));
        check($sformatf("rst_data%0d", d), rdata[d], 128'(0));
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    rst_n = 1'b1;
    armed = 1'b1;

    // Write then read back via a different byte offset in the same line.
    txn(0, 1'b1, 32'h8000_0040, D1, 128'(0), 1'b0, 5, 0, 0, 0);
    txn(0, 1'b0, 32'h8000_004C, 128'(0), D1, 1'b0, 5, 0, 0, 0);

    // Out of range; the write above the top would alias line 0 if committed.
    txn(0, 1'b1, 32'h8000_3FF0, D2, 128'(0), 1'b0, 5, 0, 0, 0);
    txn(0, 1'b1, 32'h8000_0000, D4, 128'(0), 1'b0, 5, 0, 0, 0);
    txn(0, 1'b0, 32'h7FFF_FFF0, 128'(0), 128'(0), 1'b1, 5, 0, 0, 0);
    txn(0, 1'b1, 32'h8000_4000, PA, 128'(0), 1'b1, 5, 0, 0, 0);
    txn(0, 1'b0, 32'h8000_3FF0, 128'(0), D2, 1'b0, 5, 0, 0, 0);
    txn(0, 1'b0, 32'h8000_0000, 128'(0), D4, 1'b0, 5, 0, 0, 0);

    // req held across RESP and TURN, then a second held read back to back.
    txn(0, 1'b0, 32'h8000_0040, 128'(0), D1, 1'b0, 5, 1, 0, 0);
    txn(0, 1'b0, 32'h8000_3FF0, 128'(0), D2, 1'b0, 5, 1, 0, 7);
    idle(0);

    // Inputs scrambled and req dropped while busy.
    txn(0, 1'b1, 32'h8000_0100, D5, 128'(0), 1'b0, 5, 0, 1, 0);
    txn(0, 1'b0, 32'h8000_0100, 128'(0), D5, 1'b0, 5, 0, 0, 0);

    // Reset in the middle of a write to line 5.
    txn(0, 1'b1, 32'h8000_0050, P5, 128'(0), 1'b0, 5, 0, 0, 0);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h8000_0050; wdata[0] = PA;
    n = 0;
    while (busy[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("midrst_accept", 128'(busy[0]), 128'(1));
    @(negedge clk);
    req[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 128'(busy[0]), 128'(0));
    check("midrst_data", rdata[0], 128'(0));
    repeat (8) @(negedge clk);
    txn(0, 1'b0, 32'h8000_0050, 128'(0), P5, 1'b0, 5, 0, 0, 0);

    // Latency-1 instance: back-to-back writes then reads, accepts 4 apart.
    for (int i = 0; i < 4; i++)
      txn(1, 1'b1, 32'h0000_1000 + 32'(i * 16), {4{32'hA5A5_0000 + 32'(i)}},
          128'(0), 1'b0, 2, 1, 0, (i == 0) ? 0 : 4);
    for (int i = 0; i < 4; i++)
      txn(1, 1'b0, 32'h0000_1000 + 32'(i * 16), 128'(0),
          {4{32'hA5A5_0000 + 32'(i)}}, 1'b0, 2, 1, 0, 4);
    idle(1);

    repeat (4) @(negedge clk);
    check("sb0_drained", 128'(sb0.size()), 128'(0));
    check("sb1_drained", 128'(sb1.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
